// File: rtl/load_request_unit.sv
// -----------------------------------------------------------------------------
// load_request_unit
//
// Data-memory read sequencer sitting between the memory-stage control of the
// core and the load alignment stage. A load request (byte address + load op)
// is accepted in IDLE, checked for misalignment, and turned into a single
// valid/ready word read on the data bus. The returned word is captured and
// presented together with the byte-lane offset and the load op so that the
// downstream aligner can extract and sign/zero-extend the loaded value.
// A bus watchdog terminates reads that never receive mem_ready.
//
// Optional feature (compile-time macro LOAD_MISALIGN_SPLIT_EN):
//   When defined, misaligned loads are serviced in hardware. In-word
//   misaligned halfwords use one read and a byte shift; word-crossing loads
//   use two reads (low word, then the next word after a one-cycle gap) and
//   a merge. The misaligned pulse never fires in that build.
//   When undefined, the REQ_HI path is absent and misaligned loads are
//   reported with a one-cycle misaligned pulse and no bus access.
//
// Parameters:
//   TIMEOUT_CYCLES  wait cycles in a request phase without mem_ready before
//                   the access is aborted with fault; 0 disables the watchdog
//
// Ports:
//   clk             clock
//   rst             asynchronous active-high reset
//   i_start         request strobe, only sampled while idle
//   i_addr          byte address of the load
//   i_load_op       LB/LBU/LH/LHU/LW code
//   o_busy          high from the cycle after an accepted start up to and
//                   including the done/misaligned/fault cycle
//   o_done          one-cycle pulse, data_out/addr_lsb/load_op_out valid
//   o_misaligned    one-cycle pulse, misaligned load, no bus access made
//   o_fault         one-cycle pulse, watchdog expired
//   o_data_out      captured (or merged) word
//   o_addr_lsb      byte offset for the aligner
//   o_load_op_out   latched load op
//   o_mem_valid     bus read request
//   o_mem_addr      word-aligned bus address
//   o_mem_wstrb     always 4'b0000 (read-only master)
//   i_mem_ready     bus response strobe
//   i_mem_rdata     bus read data, valid with i_mem_ready
// -----------------------------------------------------------------------------

`ifndef LOAD_OP_WIDTH
`define LOAD_OP_WIDTH 3
`endif
`ifndef LOAD_OP_LB
`define LOAD_OP_LB  3'b000
`endif
`ifndef LOAD_OP_LH
`define LOAD_OP_LH  3'b001
`endif
`ifndef LOAD_OP_LW
`define LOAD_OP_LW  3'b010
`endif
`ifndef LOAD_OP_LBU
`define LOAD_OP_LBU 3'b100
`endif
`ifndef LOAD_OP_LHU
`define LOAD_OP_LHU 3'b101
`endif

module load_request_unit #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    input  logic [31:0]               i_addr,
    input  logic [`LOAD_OP_WIDTH-1:0] i_load_op,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_misaligned,
    output logic                      o_fault,
    output logic [31:0]               o_data_out,
    output logic [1:0]                o_addr_lsb,
    output logic [`LOAD_OP_WIDTH-1:0] o_load_op_out,
    output logic                      o_mem_valid,
    output logic [31:0]               o_mem_addr,
    output logic [3:0]                o_mem_wstrb,
    input  logic                      i_mem_ready,
    input  logic [31:0]               i_mem_rdata
);

    localparam int OPW  = `LOAD_OP_WIDTH;
    localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [OPW-1:0]  OP_LH    = OPW'(`LOAD_OP_LH);
    localparam logic [OPW-1:0]  OP_LHU   = OPW'(`LOAD_OP_LHU);
    localparam logic [OPW-1:0]  OP_LW    = OPW'(`LOAD_OP_LW);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1
`ifdef LOAD_MISALIGN_SPLIT_EN
        ,
        S_GAP    = 2'd2,
        S_REQ_HI = 2'd3
`endif
    } state_t;

    state_t          r_state;
    logic            r_busy;
    logic            r_done;
    logic            r_mis;
    logic            r_fault;
    logic [31:0]     r_data;
    logic [1:0]      r_lsb;
    logic [OPW-1:0]  r_op;
    logic            r_mem_valid;
    logic [31:0]     r_mem_addr;
    logic [WD_W-1:0] r_wd_cnt;
    logic [1:0]      r_off;

    state_t          w_state_next;
    logic            w_busy_next;
    logic            w_done_next;
    logic            w_mis_next;
    logic            w_fault_next;
    logic [31:0]     w_data_next;
    logic [1:0]      w_lsb_next;
    logic [OPW-1:0]  w_op_next;
    logic            w_valid_next;
    logic [31:0]     w_addr_next;
    logic [WD_W-1:0] w_cnt_next;
    logic [1:0]      w_off_next;

    logic            w_is_half;
    logic            w_is_word;
    logic            w_wd_expired;

`ifdef LOAD_MISALIGN_SPLIT_EN
    logic [31:0]     r_lo;
    logic            r_cross;
    logic            r_inword;
    logic [31:0]     w_lo_next;
    logic            w_cross_next;
    logic            w_inword_next;
    logic            w_cross;
    logic            w_inword;
    logic [31:0]     w_merged;
`else
    logic            w_misaligned;
`endif

    assign w_is_half = (i_load_op == OP_LH) || (i_load_op == OP_LHU);
    assign w_is_word = (i_load_op == OP_LW);

    // Expiry is only possible with the watchdog enabled; mem_ready is checked
    // ahead of this in the FSM so a response on the expiry cycle still wins.
    assign w_wd_expired = (TIMEOUT_CYCLES != 0) && (r_wd_cnt == WD_LIMIT);

`ifdef LOAD_MISALIGN_SPLIT_EN
    assign w_inword = w_is_half && (i_addr[1:0] == 2'b01);
    assign w_cross  = (w_is_half && (i_addr[1:0] == 2'b11)) ||
                      (w_is_word && (i_addr[1:0] != 2'b00));

    // Low 32 bits of {H,L} >> 8*offset, written out per offset. Offset 0 can
    // never be a crossing access, so it just falls back to the low word.
    always_comb begin
        case (r_off)
            2'd1:    w_merged = {i_mem_rdata[7:0],  r_lo[31:8]};
            2'd2:    w_merged = {i_mem_rdata[15:0], r_lo[31:16]};
            2'd3:    w_merged = {i_mem_rdata[23:0], r_lo[31:24]};
            default: w_merged = r_lo;
        endcase
    end
`else
    assign w_misaligned = (w_is_half && i_addr[0]) ||
                          (w_is_word && (i_addr[1:0] != 2'b00));
`endif

    // Next-state and next-output logic. Every output is registered, so the
    // values computed here appear one cycle later. Pulses default to 0 and
    // everything else defaults to holding its current value.
    always_comb begin
        w_state_next = r_state;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        w_mis_next   = 1'b0;
        w_fault_next = 1'b0;
        w_data_next  = r_data;
        w_lsb_next   = r_lsb;
        w_op_next    = r_op;
        w_valid_next = r_mem_valid;
        w_addr_next  = r_mem_addr;
        w_cnt_next   = r_wd_cnt;
        w_off_next   = r_off;
`ifdef LOAD_MISALIGN_SPLIT_EN
        w_lo_next     = r_lo;
        w_cross_next  = r_cross;
        w_inword_next = r_inword;
`endif

        case (r_state)
            S_IDLE: begin
                // busy is still high on the cycle carrying a done/misaligned/
                // fault pulse; a start seen then belongs to a busy unit and
                // is ignored.
                w_busy_next  = 1'b0;
                w_valid_next = 1'b0;
                if (i_start && !r_busy) begin
                    w_busy_next = 1'b1;
                    w_op_next   = i_load_op;
                    w_off_next  = i_addr[1:0];
                    w_cnt_next  = '0;
`ifdef LOAD_MISALIGN_SPLIT_EN
                    w_cross_next  = w_cross;
                    w_inword_next = w_inword;
                    w_addr_next   = {i_addr[31:2], 2'b00};
                    w_valid_next  = 1'b1;
                    w_state_next  = S_REQ;
`else
                    if (w_misaligned) begin
                        w_mis_next = 1'b1;
                    end else begin
                        w_addr_next  = {i_addr[31:2], 2'b00};
                        w_valid_next = 1'b1;
                        w_state_next = S_REQ;
                    end
`endif
                end
            end

            S_REQ: begin
                if (i_mem_ready) begin
                    w_valid_next = 1'b0;
                    w_cnt_next   = '0;
`ifdef LOAD_MISALIGN_SPLIT_EN
                    if (r_cross) begin
                        w_lo_next    = i_mem_rdata;
                        w_addr_next  = r_mem_addr + 32'd4;
                        w_state_next = S_GAP;
                    end else begin
                        w_done_next  = 1'b1;
                        w_data_next  = r_inword ? {8'h00, i_mem_rdata[31:8]} : i_mem_rdata;
                        w_lsb_next   = r_inword ? 2'b00 : r_off;
                        w_state_next = S_IDLE;
                    end
`else
                    w_done_next  = 1'b1;
                    w_data_next  = i_mem_rdata;
                    w_lsb_next   = r_off;
                    w_state_next = S_IDLE;
`endif
                end else if (w_wd_expired) begin
                    w_valid_next = 1'b0;
                    w_fault_next = 1'b1;
                    w_state_next = S_IDLE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    w_cnt_next = r_wd_cnt + WD_ONE;
                end
            end

`ifdef LOAD_MISALIGN_SPLIT_EN
            // One idle bus cycle between the two halves; any stray mem_ready
            // here is ignored because no request is outstanding.
            S_GAP: begin
                w_valid_next = 1'b1;
                w_cnt_next   = '0;
                w_state_next = S_REQ_HI;
            end

            S_REQ_HI: begin
                if (i_mem_ready) begin
                    w_valid_next = 1'b0;
                    w_cnt_next   = '0;
                    w_done_next  = 1'b1;
                    w_data_next  = w_merged;
                    w_lsb_next   = 2'b00;
                    w_state_next = S_IDLE;
                end else if (w_wd_expired) begin
                    w_valid_next = 1'b0;
                    w_fault_next = 1'b1;
                    w_state_next = S_IDLE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    w_cnt_next = r_wd_cnt + WD_ONE;
                end
            end
`endif

            default: begin
                w_valid_next = 1'b0;
                w_busy_next  = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and output registers. The asynchronous reset drops mem_valid at
    // once, so any response still in flight is simply never looked at.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mis       <= 1'b0;
            r_fault     <= 1'b0;
            r_data      <= '0;
            r_lsb       <= '0;
            r_op        <= '0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_wd_cnt    <= '0;
            r_off       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_mis       <= w_mis_next;
            r_fault     <= w_fault_next;
            r_data      <= w_data_next;
            r_lsb       <= w_lsb_next;
            r_op        <= w_op_next;
            r_mem_valid <= w_valid_next;
            r_mem_addr  <= w_addr_next;
            r_wd_cnt    <= w_cnt_next;
            r_off       <= w_off_next;
        end
    end

`ifdef LOAD_MISALIGN_SPLIT_EN
    // Bookkeeping for split accesses: the captured low word and how the
    // access was classified when it was accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo     <= '0;
            r_cross  <= 1'b0;
            r_inword <= 1'b0;
        end else begin
            r_lo     <= w_lo_next;
            r_cross  <= w_cross_next;
            r_inword <= w_inword_next;
        end
    end
`endif

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_misaligned  = r_mis;
    assign o_fault       = r_fault;
    assign o_data_out    = r_data;
    assign o_addr_lsb    = r_lsb;
    assign o_load_op_out = r_op;
    assign o_mem_valid   = r_mem_valid;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wstrb   = 4'b0000;

endmodule

// File: tb/tb_load_request_unit.sv
// -----------------------------------------------------------------------------
// tb_load_request_unit
//
// Self-checking bench for load_request_unit. Two instances share one set of
// stimulus signals through a select: dutMain uses the default watchdog
// length, dutWd uses a short watchdog of 4 cycles. Expected completion events
// are pushed into a scoreboard queue when a request is driven and popped by a
// monitor when the selected instance pulses done/misaligned/fault.
// -----------------------------------------------------------------------------

`timescale 1ns/1ps

module tb_load_request_unit;

    localparam int WD_SHORT = 4;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    localparam int EV_DONE  = 1;
    localparam int EV_MIS   = 2;
    localparam int EV_FAULT = 3;

    typedef struct {
        int         kind;
        logic [31:0] data;
        logic [1:0]  lsb;
        logic [2:0]  op;
    } ExpEvent;

    ExpEvent sbQ[$];

    int cmpCount  = 0;
    int failCount = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        start = 1'b0;
    logic [31:0] addr = '0;
    logic [2:0]  loadOp = '0;
    logic        memReady = 1'b0;
    logic [31:0] memRdata = '0;

    logic        aStart, bStart, aReady, bReady;
    logic        aBusy, aDone, aMis, aFault, aValid;
    logic        bBusy, bDone, bMis, bFault, bValid;
    logic [31:0] aData, aMemAddr, bData, bMemAddr;
    logic [1:0]  aLsb, bLsb;
    logic [2:0]  aOp, bOp;
    logic [3:0]  aWstrb, bWstrb;

    logic        obsBusy, obsDone, obsMis, obsFault, obsValid;
    logic [31:0] obsData, obsMemAddr;
    logic [1:0]  obsLsb;
    logic [2:0]  obsOp;
    logic [3:0]  obsWstrb;

    assign aStart = start & ~sel;
    assign bStart = start & sel;
    assign aReady = memReady & ~sel;
    assign bReady = memReady & sel;

    assign obsBusy    = sel ? bBusy    : aBusy;
    assign obsDone    = sel ? bDone    : aDone;
    assign obsMis     = sel ? bMis     : aMis;
    assign obsFault   = sel ? bFault   : aFault;
    assign obsValid   = sel ? bValid   : aValid;
    assign obsData    = sel ? bData    : aData;
    assign obsMemAddr = sel ? bMemAddr : aMemAddr;
    assign obsLsb     = sel ? bLsb     : aLsb;
    assign obsOp      = sel ? bOp      : aOp;
    assign obsWstrb   = sel ? bWstrb   : aWstrb;

    load_request_unit dutMain (
        .clk           (clk),
        .rst           (rst),
        .i_start       (aStart),
        .i_addr        (addr),
        .i_load_op     (loadOp),
        .o_busy        (aBusy),
        .o_done        (aDone),
        .o_misaligned  (aMis),
        .o_fault       (aFault),
        .o_data_out    (aData),
        .o_addr_lsb    (aLsb),
        .o_load_op_out (aOp),
        .o_mem_valid   (aValid),
        .o_mem_addr    (aMemAddr),
        .o_mem_wstrb   (aWstrb),
        .i_mem_ready   (aReady),
        .i_mem_rdata   (memRdata)
    );

    load_request_unit #(.TIMEOUT_CYCLES(WD_SHORT)) dutWd (
        .clk           (clk),
        .rst           (rst),
        .i_start       (bStart),
        .i_addr        (addr),
        .i_load_op     (loadOp),
        .o_busy        (bBusy),
        .o_done        (bDone),
        .o_misaligned  (bMis),
        .o_fault       (bFault),
        .o_data_out    (bData),
        .o_addr_lsb    (bLsb),
        .o_load_op_out (bOp),
        .o_mem_valid   (bValid),
        .o_mem_addr    (bMemAddr),
        .o_mem_wstrb   (bWstrb),
        .i_mem_ready   (bReady),
        .i_mem_rdata   (memRdata)
    );

    // Free-running 10ns clock.
    always #5 clk = ~clk;

    // Hard stop in case something upstream never returns.
    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: observed simulation still running, expected completion");
        $fatal(1, "[TB] aborted");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        cmpCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: whenever the selected instance reports a completion
    // event, pop the oldest expectation and compare kind, and on done also the
    // presented data, byte offset and load op. Sampled on the falling edge.
    always @(negedge clk) begin
        ExpEvent expEv;
        int kindObs;
        if (!rst && (obsDone || obsMis || obsFault)) begin
            checkOutput("eventExclusive", 32'(obsDone) + 32'(obsMis) + 32'(obsFault), 1);
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedEvent", {29'd0, obsDone, obsMis, obsFault}, 0);
            end else begin
                expEv   = sbQ.pop_front();
                kindObs = obsDone ? EV_DONE : (obsMis ? EV_MIS : EV_FAULT);
                checkOutput("eventKind", kindObs, expEv.kind);
                if (obsDone) begin
                    checkOutput("dataOut",   obsData, expEv.data);
                    checkOutput("addrLsb",   {30'd0, obsLsb}, {30'd0, expEv.lsb});
                    checkOutput("loadOpOut", {29'd0, obsOp}, {29'd0, expEv.op});
                end
            end
        end
    end

    // Drives one load request and plays the bus slave for it. waits is the
    // number of cycles mem_ready stays low after each mem_valid (negative
    // means never respond). nReads is 0 for a misaligned reject.
    task automatic applyStimulus(input logic [31:0] a, input logic [2:0] op, input int waits,
                                 input logic [31:0] lo, input logic [31:0] hi,
                                 input int kind, input logic [31:0] expData, input logic [1:0] expLsb,
                                 input int nReads, input logic [31:0] addr0, input logic [31:0] addr1);
        int validCycles;
        logic [31:0] busAddr;
        sbQ.push_back('{kind, expData, expLsb, op});
        start  = 1'b1;
        addr   = a;
        loadOp = op;
        advance();
        start = 1'b0;
        checkOutput("busyAfterStart", obsBusy, 1);
        if (nReads == 0) begin
            checkOutput("noBusAccess", obsValid, 0);
            checkOutput("misalignPulse", obsMis, 1);
            advance();
            checkOutput("busyClearMis", obsBusy, 0);
            checkOutput("noBusAccessLate", obsValid, 0);
            return;
        end
        for (int r = 0; r < nReads; r++) begin
            busAddr = (r == 0) ? addr0 : addr1;
            if (r > 0) begin
                checkOutput("gapCycle", obsValid, 0);
                advance();
            end
            checkOutput("memValid", obsValid, 1);
            checkOutput("memAddr", obsMemAddr, busAddr);
            checkOutput("memWstrb", {28'd0, obsWstrb}, 0);
            if (waits < 0) begin
                validCycles = 0;
                for (int c = 0; c < 40; c++) begin
                    if (!obsValid) break;
                    validCycles++;
                    advance();
                end
                checkOutput("wdValidCycles", validCycles, WD_SHORT + 1);
                checkOutput("faultPulse", obsFault, 1);
                checkOutput("noDoneOnFault", obsDone, 0);
                advance();
                checkOutput("busyClearFault", obsBusy, 0);
                return;
            end
            for (int w = 0; w < waits; w++) begin
                memReady = 1'b0;
                start    = (w == 0);
                addr     = 32'h0000_5000;
                advance();
                start = 1'b0;
                checkOutput("validHeld", obsValid, 1);
                checkOutput("addrHeld", obsMemAddr, busAddr);
            end
            memReady = 1'b1;
            memRdata = (r == 0) ? lo : hi;
            advance();
            memReady = 1'b0;
            memRdata = '0;
        end
        checkOutput("doneTiming", obsDone, 1);
        checkOutput("validDropped", obsValid, 0);
        advance();
        checkOutput("busyClearDone", obsBusy, 0);
        advance();
    endtask

    // Main sequence.
    initial begin
        $display("[TB] load_request_unit bench starting");
        #3;
        checkOutput("rstBusy",  obsBusy, 0);
        checkOutput("rstValid", obsValid, 0);
        checkOutput("rstDone",  obsDone, 0);
        checkOutput("rstData",  obsData, 0);
        checkOutput("rstAddr",  obsMemAddr, 0);
        advance();
        advance();
        rst = 1'b0;
        advance();

        applyStimulus(32'h0000_1000, OP_LW, 0, 32'hDEAD_BEEF, 32'h0, EV_DONE,
                      32'hDEAD_BEEF, 2'd0, 1, 32'h0000_1000, 32'h0);
        applyStimulus(32'h0000_2003, OP_LBU, 5, 32'h1122_3344, 32'h0, EV_DONE,
                      32'h1122_3344, 2'd3, 1, 32'h0000_2000, 32'h0);
        applyStimulus(32'h0000_2002, OP_LH, 2, 32'hA5A5_0F0F, 32'h0, EV_DONE,
                      32'hA5A5_0F0F, 2'd2, 1, 32'h0000_2000, 32'h0);
        applyStimulus(32'h0000_2001, OP_LB, 0, 32'h0102_0304, 32'h0, EV_DONE,
                      32'h0102_0304, 2'd1, 1, 32'h0000_2000, 32'h0);
`ifdef LOAD_MISALIGN_SPLIT_EN
        applyStimulus(32'h0000_1001, OP_LH, 1, 32'hAABB_CCDD, 32'h0, EV_DONE,
                      32'h00AA_BBCC, 2'd0, 1, 32'h0000_1000, 32'h0);
        applyStimulus(32'h0000_1002, OP_LW, 0, 32'h4433_2211, 32'h8877_6655, EV_DONE,
                      32'h6655_4433, 2'd0, 2, 32'h0000_1000, 32'h0000_1004);
        applyStimulus(32'h0000_1003, OP_LHU, 1, 32'h4433_2211, 32'h8877_6655, EV_DONE,
                      32'h7766_5544, 2'd0, 2, 32'h0000_1000, 32'h0000_1004);
        applyStimulus(32'hFFFF_FFFE, OP_LW, 0, 32'h4433_2211, 32'h8877_6655, EV_DONE,
                      32'h6655_4433, 2'd0, 2, 32'hFFFF_FFFC, 32'h0000_0000);
`else
        applyStimulus(32'h0000_1001, OP_LH, 0, 32'h0, 32'h0, EV_MIS,
                      32'h0, 2'd0, 0, 32'h0, 32'h0);
        applyStimulus(32'h0000_1002, OP_LW, 0, 32'h0, 32'h0, EV_MIS,
                      32'h0, 2'd0, 0, 32'h0, 32'h0);
        applyStimulus(32'h0000_1003, OP_LHU, 0, 32'h0, 32'h0, EV_MIS,
                      32'h0, 2'd0, 0, 32'h0, 32'h0);
        checkOutput("misDataHeld", obsData, 32'h0102_0304);
`endif

        // Short-watchdog instance: response exactly on the expiry cycle wins,
        // then a read that never gets a response faults.
        sel = 1'b1;
        advance();
        applyStimulus(32'h0000_3000, OP_LW, WD_SHORT, 32'hCAFE_F00D, 32'h0, EV_DONE,
                      32'hCAFE_F00D, 2'd0, 1, 32'h0000_3000, 32'h0);
        applyStimulus(32'h0000_3000, OP_LW, -1, 32'h0, 32'h0, EV_FAULT,
                      32'h0, 2'd0, 1, 32'h0000_3000, 32'h0);
        checkOutput("faultDataHeld", obsData, 32'hCAFE_F00D);
        sel = 1'b0;
        advance();

        // Reset in the middle of an outstanding read.
        start  = 1'b1;
        addr   = 32'h0000_4000;
        loadOp = OP_LW;
        advance();
        start = 1'b0;
        checkOutput("preRstValid", obsValid, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRstValid", obsValid, 0);
        checkOutput("midRstBusy",  obsBusy, 0);
        checkOutput("midRstData",  obsData, 0);
        checkOutput("midRstLsb",   {30'd0, obsLsb}, 0);
        checkOutput("midRstOp",    {29'd0, obsOp}, 0);
        checkOutput("midRstAddr",  obsMemAddr, 0);
        memReady = 1'b1;
        memRdata = 32'h1234_5678;
        advance();
        advance();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            advance();
            checkOutput("lateReadyNoDone", obsDone, 0);
            checkOutput("idleReadyNoBusy", obsBusy, 0);
        end
        memReady = 1'b0;
        memRdata = '0;
        advance();

        applyStimulus(32'h0000_4000, OP_LW, 1, 32'h0BAD_C0DE, 32'h0, EV_DONE,
                      32'h0BAD_C0DE, 2'd0, 1, 32'h0000_4000, 32'h0);

        advance();
        checkOutput("scoreboardDrained", sbQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
        $finish;
    end

endmodule
